vga_write_scheduler: RTL and testbench
======================================

# vga_write_scheduler

Write scheduler for the VGA pointer memory port. Accepts address/data writes from the PicoBlaze I/O bus into a small FIFO and replays them to the pointer memory write interface (MemAddr, MemData, Write) only while the vertical sync window is open, so pointer updates never tear a visible frame. Sits between the PicoBlaze port decoder and the pointer block, and takes over the address/data/write registers of the VGA central controller.

## Interface
- DEPTH, 8, FIFO entries; power of two, 2..16
- PORT_ADDR, 8'd40, port ID that latches the pending memory address
- PORT_DATA, 8'd41, port ID that pushes {pending address, data} into the FIFO
- PORT_CTRL, 8'd42, port ID for control writes
- PORT_STAT, 8'd3, port ID for status reads

- CLK  in  1  system clock; all logic on rising edge
- RESET  in  1  synchronous, active-low reset
- Port_ID  in  8  PicoBlaze port ID
- IN_DATA  in  8  PicoBlaze output data
- Write_Strobe  in  1  PicoBlaze write strobe, one cycle per write
- Read_Strobe  in  1  PicoBlaze read strobe
- VSync  in  1  vertical sync from sync counters, active low; low = commit window open
- OUT_DATA  out  8  status byte on PORT_STAT read, else 8'h00 (combinational)
- MemAddr  out  4  pointer memory address (registered)
- MemData  out  8  pointer memory data (registered)
- Write  out  1  one-cycle write pulse to pointer memory (registered)
- Busy  out  1  high when FIFO non-empty or Write high

## Operation
- Reset (RESET=0 at an edge): FIFO flushed (count 0), pending address 4'hF, MemAddr 4'hF, MemData 8'h00, Write 0, immediate 0, overflow 0, state IDLE. Reset mid-drain drops all queued entries; any in-flight Write deasserts at that edge.
- Write_Strobe & Port_ID==PORT_ADDR: pending address <= IN_DATA[3:0]. No FIFO effect.
- Write_Strobe & Port_ID==PORT_DATA: if not full, push {pending address, IN_DATA}; if full, entry dropped, overflow <= 1 (sticky). Pending address unchanged, so consecutive data writes reuse it.
- Write_Strobe & Port_ID==PORT_CTRL: immediate <= IN_DATA[0]; IN_DATA[1]=1 clears overflow (clear wins over a same-cycle overflow set).
- Other port IDs ignored. Read_Strobe has no side effects.
- Status byte: {overflow, immediate, empty, full, count[3:0]}; count saturates its 4-bit field only at DEPTH=16 (count 16 reads as 4'hF with full=1).
- Window open = (VSync==0) | immediate.
- Drain FSM:
  - IDLE: Write 0. If count>0 and window open -> ISSUE.
  - ISSUE: MemAddr/MemData <= FIFO head, Write <= 1, pop head -> GAP.
  - GAP: Write <= 0 -> IDLE.
- Max drain rate one entry per 3 cycles. Window closing in ISSUE or GAP does not abort the current write; next entry waits for the window.
- Entries committed strictly in push order; MemAddr/MemData hold last committed values between writes.
- Full/empty from registered count. Push and pop in the same cycle: both take effect, count unchanged. Push when full is rejected even if a pop occurs that cycle.
- Pointers wrap modulo DEPTH.

## Timing
- Push at edge k (strobe sampled): count updated after k.
- With window open and FSM in IDLE: ISSUE entered at k+1, Write=1 during the cycle after edge k+2, Write=0 after k+3.
- OUT_DATA valid in the same cycle as Read_Strobe; reflects registered state, not a same-cycle push.
- VSync sampled directly, no extra synchronizer (same clock domain).
- Busy registered-equivalent: derived from count and Write registers only.

## Test plan
- Reset: hold RESET=0 two cycles with strobes active -> MemAddr=4'hF, MemData=8'h00, Write=0, status read = 8'h20 (empty=1, count 0).
- Gated commit: VSync=1, write port 40←5, port 41←8'hA7 -> no Write, status count=1; drop VSync to 0 -> exactly one Write pulse with MemAddr=5, MemData=8'hA7, then status=8'h20.
- Ordering/rate: immediate=1, push data 8'h01..8'h04 at addr 2 back to back -> four Write pulses, each 3 cycles apart, data 01,02,03,04 in order.
- Overflow: VSync=1, push 9 entries (DEPTH=8) -> status=8'h98 (overflow, full, count 8); ctrl write 8'h02 -> overflow clear; drain yields first 8 entries only.
- Simultaneous push/pop: VSync=0 with 3 entries queued, push during ISSUE -> count unchanged that cycle, all 4 entries committed in order.
- Reset mid-drain: 4 queued, assert RESET=0 the cycle Write=1 -> Write 0 next cycle, FIFO empty, no further writes after release.

Source files
------------

// File: rtl/vga_write_scheduler_if.sv
// PicoBlaze I/O bus and pointer-memory write port seen by the VGA write scheduler.
// The master side drives port writes/reads; the slave side answers status and drives memory writes.
interface vga_write_scheduler_if;
    logic [7:0] Port_ID;
    logic [7:0] IN_DATA;
    logic       Write_Strobe;
    logic       Read_Strobe;
    logic [7:0] OUT_DATA;
    logic [3:0] MemAddr;
    logic [7:0] MemData;
    logic       Write;

    modport master (
        output Port_ID,
        output IN_DATA,
        output Write_Strobe,
        output Read_Strobe,
        input  OUT_DATA,
        input  MemAddr,
        input  MemData,
        input  Write
    );

    modport slave (
        input  Port_ID,
        input  IN_DATA,
        input  Write_Strobe,
        input  Read_Strobe,
        output OUT_DATA,
        output MemAddr,
        output MemData,
        output Write
    );
endinterface

// File: rtl/vga_write_scheduler.sv
// Queues PicoBlaze pointer-memory writes and replays them only while the vertical sync
// window is open (or immediate mode is set), one entry every three cycles, in push order.
module vga_write_scheduler #(
    parameter int         DEPTH     = 8,
    parameter logic [7:0] PORT_ADDR = 8'd40,
    parameter logic [7:0] PORT_DATA = 8'd41,
    parameter logic [7:0] PORT_CTRL = 8'd42,
    parameter logic [7:0] PORT_STAT = 8'd3
) (
    input  logic CLK,
    input  logic RESET,
    input  logic VSync,
    output logic Busy,
    vga_write_scheduler_if.slave bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP
    } state_t;

    state_t state;
    state_t state_next;

    logic [11:0]      fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [3:0]       pending_addr;
    logic             immediate;
    logic             overflow;

    logic [3:0]       mem_addr_q;
    logic [7:0]       mem_data_q;
    logic             write_q;

    logic             wr_addr_sel;
    logic             wr_data_sel;
    logic             wr_ctrl_sel;
    logic             rd_stat_sel;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             issue;
    logic             window_open;
    logic [4:0]       count_ext;
    logic [3:0]       count_field;
    logic [7:0]       status;

    assign wr_addr_sel = bus.Write_Strobe && (bus.Port_ID == PORT_ADDR);
    assign wr_data_sel = bus.Write_Strobe && (bus.Port_ID == PORT_DATA);
    assign wr_ctrl_sel = bus.Write_Strobe && (bus.Port_ID == PORT_CTRL);
    assign rd_stat_sel = bus.Read_Strobe  && (bus.Port_ID == PORT_STAT);

    assign full        = (count == FULL_COUNT);
    assign empty       = (count == '0);
    assign window_open = !VSync || immediate;

    // A push into a full FIFO is rejected even if the head is popped in the same cycle.
    assign push = wr_data_sel && !full;
    assign pop  = issue;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && window_open) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                issue      = 1'b1;
                state_next = GAP;
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET && push) begin
            fifo_mem[wr_ptr] <= {pending_addr, bus.IN_DATA};
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Overflow clear from a control write takes priority over a same-cycle overflow.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            pending_addr <= 4'hF;
            immediate    <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            if (wr_addr_sel) begin
                pending_addr <= bus.IN_DATA[3:0];
            end
            if (wr_ctrl_sel) begin
                immediate <= bus.IN_DATA[0];
            end
            if (wr_ctrl_sel && bus.IN_DATA[1]) begin
                overflow <= 1'b0;
            end else if (wr_data_sel && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // MemAddr/MemData hold the last committed entry; Write is a single-cycle pulse.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            mem_addr_q <= 4'hF;
            mem_data_q <= 8'h00;
            write_q    <= 1'b0;
        end else begin
            write_q <= issue;
            if (issue) begin
                {mem_addr_q, mem_data_q} <= fifo_mem[rd_ptr];
            end
        end
    end

    assign count_ext   = 5'(count);
    assign count_field = count_ext[4] ? 4'hF : count_ext[3:0];
    assign status      = {overflow, immediate, empty, full, count_field};

    assign bus.OUT_DATA = rd_stat_sel ? status : 8'h00;
    assign bus.MemAddr  = mem_addr_q;
    assign bus.MemData  = mem_data_q;
    assign bus.Write    = write_q;
    assign Busy         = !empty || write_q;

endmodule

// File: tb/tb_vga_write_scheduler.sv
// Directed bench for vga_write_scheduler: gated commit, ordering/rate, overflow,
// simultaneous push/pop and reset during a drain.
module tb_vga_write_scheduler;

    localparam logic [7:0] PORT_ADDR = 8'd40;
    localparam logic [7:0] PORT_DATA = 8'd41;
    localparam logic [7:0] PORT_CTRL = 8'd42;
    localparam logic [7:0] PORT_STAT = 8'd3;

    logic CLK;
    logic RESET;
    logic VSync;
    logic Busy;

    vga_write_scheduler_if bus ();

    vga_write_scheduler dut (
        .CLK   (CLK),
        .RESET (RESET),
        .VSync (VSync),
        .Busy  (Busy),
        .bus   (bus)
    );

    int tests_run = 0;
    int failures  = 0;
    int cyc       = 0;

    logic [3:0] pulse_addr [64];
    logic [7:0] pulse_data [64];
    int         pulse_cyc  [64];
    int         pulse_count = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Every cycle with Write high is logged as one committed entry.
    always @(negedge CLK) begin
        if (bus.Write === 1'b1 && pulse_count < 64) begin
            pulse_addr[pulse_count] = bus.MemAddr;
            pulse_data[pulse_count] = bus.MemData;
            pulse_cyc[pulse_count]  = cyc;
            pulse_count             = pulse_count + 1;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic applyStimulus(input logic [7:0] port, input logic [7:0] data);
        bus.Port_ID      = port;
        bus.IN_DATA      = data;
        bus.Write_Strobe = 1'b1;
        tick();
        bus.Write_Strobe = 1'b0;
        bus.Port_ID      = 8'h00;
    endtask

    task automatic readStatus(output logic [7:0] value);
        bus.Port_ID     = PORT_STAT;
        bus.Read_Strobe = 1'b1;
        #1;
        value           = bus.OUT_DATA;
        bus.Read_Strobe = 1'b0;
        bus.Port_ID     = 8'h00;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] stat;
        int base;
        int push_cyc;
        bit seen;

        bus.Port_ID      = PORT_DATA;
        bus.IN_DATA      = 8'h55;
        bus.Write_Strobe = 1'b1;
        bus.Read_Strobe  = 1'b0;
        RESET            = 1'b0;
        VSync            = 1'b1;

        // Reset held two cycles with a data strobe active.
        ticks(2);
        bus.Write_Strobe = 1'b0;
        checkOutput("rst_memaddr", 32'(bus.MemAddr), 32'h0F);
        checkOutput("rst_memdata", 32'(bus.MemData), 32'h00);
        checkOutput("rst_write", 32'(bus.Write), 32'h0);
        checkOutput("rst_busy", 32'(Busy), 32'h0);
        readStatus(stat);
        checkOutput("rst_status", 32'(stat), 32'h20);
        RESET = 1'b1;
        tick();

        // Gated commit: nothing leaves while VSync is high.
        base = pulse_count;
        applyStimulus(PORT_ADDR, 8'h05);
        applyStimulus(PORT_DATA, 8'hA7);
        applyStimulus(8'h07, 8'h99);
        ticks(5);
        checkOutput("gate_no_write", 32'(pulse_count - base), 32'd0);
        readStatus(stat);
        checkOutput("gate_status", 32'(stat), 32'h01);
        checkOutput("gate_busy", 32'(Busy), 32'h1);
        bus.Port_ID     = PORT_ADDR;
        bus.Read_Strobe = 1'b1;
        #1;
        checkOutput("other_port_read", 32'(bus.OUT_DATA), 32'h00);
        bus.Read_Strobe = 1'b0;
        bus.Port_ID     = 8'h00;
        VSync = 1'b0;
        ticks(8);
        checkOutput("gate_pulses", 32'(pulse_count - base), 32'd1);
        checkOutput("gate_addr", 32'(pulse_addr[base]), 32'h5);
        checkOutput("gate_data", 32'(pulse_data[base]), 32'hA7);
        checkOutput("gate_hold_addr", 32'(bus.MemAddr), 32'h5);
        checkOutput("gate_hold_data", 32'(bus.MemData), 32'hA7);
        readStatus(stat);
        checkOutput("gate_status_after", 32'(stat), 32'h20);
        VSync = 1'b1;
        tick();

        // Immediate mode: four back-to-back pushes drain three cycles apart.
        applyStimulus(PORT_CTRL, 8'h01);
        readStatus(stat);
        checkOutput("imm_status", 32'(stat), 32'h60);
        applyStimulus(PORT_ADDR, 8'h02);
        base = pulse_count;
        applyStimulus(PORT_DATA, 8'h01);
        push_cyc = cyc;
        applyStimulus(PORT_DATA, 8'h02);
        applyStimulus(PORT_DATA, 8'h03);
        applyStimulus(PORT_DATA, 8'h04);
        ticks(20);
        checkOutput("order_pulses", 32'(pulse_count - base), 32'd4);
        checkOutput("order_latency", 32'(pulse_cyc[base] - push_cyc), 32'd2);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("order_data%0d", i), 32'(pulse_data[base + i]), 32'(i + 1));
            checkOutput($sformatf("order_addr%0d", i), 32'(pulse_addr[base + i]), 32'h2);
            if (i > 0) begin
                checkOutput($sformatf("order_gap%0d", i), 32'(pulse_cyc[base + i] - pulse_cyc[base + i - 1]), 32'd3);
            end
        end
        applyStimulus(PORT_CTRL, 8'h00);

        // Overflow: nine pushes into eight entries, then clear and drain.
        applyStimulus(PORT_ADDR, 8'h03);
        base = pulse_count;
        for (int i = 0; i < 9; i++) applyStimulus(PORT_DATA, 8'(8'h10 + i));
        ticks(3);
        checkOutput("ovf_no_write", 32'(pulse_count - base), 32'd0);
        readStatus(stat);
        checkOutput("ovf_status", 32'(stat), 32'h98);
        applyStimulus(PORT_CTRL, 8'h02);
        readStatus(stat);
        checkOutput("ovf_cleared", 32'(stat), 32'h18);
        VSync = 1'b0;
        ticks(32);
        checkOutput("ovf_pulses", 32'(pulse_count - base), 32'd8);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("ovf_data%0d", i), 32'(pulse_data[base + i]), 32'(8'h10 + i));
        end
        readStatus(stat);
        checkOutput("ovf_status_after", 32'(stat), 32'h20);
        VSync = 1'b1;
        tick();

        // Push lands on the same edge as the ISSUE pop.
        applyStimulus(PORT_ADDR, 8'h06);
        base = pulse_count;
        applyStimulus(PORT_DATA, 8'h21);
        applyStimulus(PORT_DATA, 8'h22);
        applyStimulus(PORT_DATA, 8'h23);
        VSync = 1'b0;
        tick();
        applyStimulus(PORT_DATA, 8'h24);
        checkOutput("sim_write", 32'(bus.Write), 32'h1);
        readStatus(stat);
        checkOutput("sim_status", 32'(stat), 32'h03);
        ticks(20);
        checkOutput("sim_pulses", 32'(pulse_count - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("sim_data%0d", i), 32'(pulse_data[base + i]), 32'(8'h21 + i));
            checkOutput($sformatf("sim_addr%0d", i), 32'(pulse_addr[base + i]), 32'h6);
        end
        VSync = 1'b1;
        tick();

        // Reset asserted in the cycle Write is high.
        applyStimulus(PORT_ADDR, 8'h09);
        base = pulse_count;
        for (int i = 0; i < 4; i++) applyStimulus(PORT_DATA, 8'(8'h31 + i));
        VSync = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (bus.Write === 1'b1) seen = 1'b1;
        end
        checkOutput("rst_mid_wait", 32'(seen), 32'h1);
        RESET = 1'b0;
        tick();
        checkOutput("rst_mid_write", 32'(bus.Write), 32'h0);
        readStatus(stat);
        checkOutput("rst_mid_status", 32'(stat), 32'h20);
        RESET = 1'b1;
        ticks(15);
        checkOutput("rst_mid_pulses", 32'(pulse_count - base), 32'd1);
        checkOutput("rst_mid_data", 32'(pulse_data[base]), 32'h31);
        checkOutput("rst_mid_busy", 32'(Busy), 32'h0);
        checkOutput("rst_mid_memaddr", 32'(bus.MemAddr), 32'h0F);
        checkOutput("rst_mid_memdata", 32'(bus.MemData), 32'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
